// File: rtl/button_conditioner.sv
// button_conditioner: per-channel synchronizer, debouncer and press-event
// generator for mechanical buttons or DIP switches.
//
// Each channel provides a debounced level and three event pulses:
//   press_o   : the press has been accepted
//   release_o : the release has been accepted
//   long_o    : the press has been held for LONG_CYCLES
//
// Event protocol: each pulse acts as a valid strobe with no ready input, so
// the consumer cannot apply backpressure. A pulse is high for exactly one
// clock and is registered. The three pulses of one channel never overlap.
//
// The 2-bit state of every channel is exported on fsm_state. It is packed
// two bits per channel (channel i uses bits [2*i+1:2*i]).
module button_conditioner #(
   parameter int N               = 4,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int LONG_CYCLES     = 50000000,
   parameter int ACTIVE_LOW      = 1
) (
   input  logic           clock,
   input  logic           reset_n,
   input  logic [N-1:0]   button_raw,
   output logic [N-1:0]   level_o,
   output logic [N-1:0]   press_o,
   output logic [N-1:0]   release_o,
   output logic [N-1:0]   long_o,
   output logic [2*N-1:0] fsm_state
);

   // Counter widths. The debounce counter needs only to reach
   // DEBOUNCE_CYCLES-1. The hold counter needs only to reach LONG_CYCLES-1.
   localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [LONG_W-1:0] HOLD_MAX = LONG_W'(LONG_CYCLES - 1);

   // This is the raw pin level of a button that is not pressed. The
   // synchronizer resets to this value, so leaving reset never looks like
   // a press edge.
   localparam logic RELEASED_RAW = (ACTIVE_LOW != 0);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic [N-1:0] sync_meta;
   logic [N-1:0] sync_stable;
   logic [N-1:0] sync_pressed;

   // Two-flop synchronizer for the asynchronous raw inputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta   <= {N{RELEASED_RAW}};
         sync_stable <= {N{RELEASED_RAW}};
      end else begin
         sync_meta   <= button_raw;
         sync_stable <= sync_meta;
      end
   end

   // Normalise polarity so that 1 always means "pressed" downstream.
   assign sync_pressed = (ACTIVE_LOW != 0) ? ~sync_stable : sync_stable;

   for (genvar i = 0; i < N; i++) begin : g_chan
      state_t              state_q, state_d;
      logic [DEB_W-1:0]    deb_q, deb_d;
      logic [LONG_W-1:0]   hold_q, hold_d;
      logic [LONG_W-1:0]   hold_next;
      logic                long_done_q, long_done_d;
      logic                long_hit;
      logic                level_q, level_d;
      logic                press_q, press_d;
      logic                release_q, release_d;
      logic                long_q, long_d;

      // Hold time saturates, so a very long hold never wraps and re-fires.
      assign hold_next = (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;

      // The long event fires once per press, in the cycle that follows the
      // hold counter reaching its limit.
      assign long_hit  = (hold_q == HOLD_MAX) && !long_done_q;

      // State, counters and registered outputs of this channel.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            state_q     <= IDLE;
            deb_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
         end else begin
            state_q     <= state_d;
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
         end
      end

      // Next-state and next-output logic of the debounce FSM.
      always_comb begin
         state_d     = state_q;
         deb_d       = deb_q;
         hold_d      = hold_q;
         long_done_d = long_done_q;
         level_d     = level_q;
         press_d     = 1'b0;
         release_d   = 1'b0;
         long_d      = 1'b0;

         unique case (state_q)
            IDLE: begin
               if (sync_pressed[i]) begin
                  state_d = PRESS_WAIT;
                  deb_d   = '0;
               end
            end

            PRESS_WAIT: begin
               if (!sync_pressed[i]) begin
                  state_d = IDLE;
               end else if (deb_q == DEB_MAX) begin
                  state_d     = HELD;
                  level_d     = 1'b1;
                  press_d     = 1'b1;
                  hold_d      = '0;
                  long_done_d = 1'b0;
               end else begin
                  deb_d = deb_q + 1'b1;
               end
            end

            HELD: begin
               hold_d = hold_next;
               if (long_hit) begin
                  long_d      = 1'b1;
                  long_done_d = 1'b1;
               end
               if (!sync_pressed[i]) begin
                  state_d = RELEASE_WAIT;
                  deb_d   = '0;
               end
            end

            RELEASE_WAIT: begin
               // Hold time keeps accruing through a release bounce. The only
               // time a long event is suppressed is on the release edge.
               hold_d = hold_next;
               if (sync_pressed[i]) begin
                  state_d = HELD;
                  if (long_hit) begin
                     long_d      = 1'b1;
                     long_done_d = 1'b1;
                  end
               end else if (deb_q == DEB_MAX) begin
                  state_d     = IDLE;
                  level_d     = 1'b0;
                  release_d   = 1'b1;
                  long_done_d = 1'b1;
               end else begin
                  deb_d = deb_q + 1'b1;
                  if (long_hit) begin
                     long_d      = 1'b1;
                     long_done_d = 1'b1;
                  end
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end

      assign level_o[i]           = level_q;
      assign press_o[i]           = press_q;
      assign release_o[i]         = release_q;
      assign long_o[i]            = long_q;
      assign fsm_state[2*i +: 2]  = state_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed test of button_conditioner with
// DEBOUNCE_CYCLES=4, LONG_CYCLES=10, N=4 and ACTIVE_LOW=1.
//
// Each expected event is packed as {edge number, kind, channel} and pushed
// onto a queue. A monitor pops one entry for every pulse the DUT presents.
//
// "Edge n" means the n-th rising clock edge since time zero. A value
// sampled on the falling edge after edge n sees cyc == n.
module tb_button_conditioner;

   localparam int N    = 4;
   localparam int DEB  = 4;
   localparam int LONG = 10;

   localparam logic [3:0] K_PRESS   = 4'd1;
   localparam logic [3:0] K_RELEASE = 4'd2;
   localparam logic [3:0] K_LONG    = 4'd3;

   logic           clock;
   logic           reset_n;
   logic [N-1:0]   button_raw;
   logic [N-1:0]   level_o;
   logic [N-1:0]   press_o;
   logic [N-1:0]   release_o;
   logic [N-1:0]   long_o;
   logic [2*N-1:0] fsm_state;

   int cyc;
   int checks;
   int fails;

   logic [23:0] exp_q[$];
   logic [23:0] mon_act;
   logic [23:0] mon_exp;
   logic [2:0]  mon_ev;

   button_conditioner #(
      .N              (N),
      .DEBOUNCE_CYCLES(DEB),
      .LONG_CYCLES    (LONG),
      .ACTIVE_LOW     (1)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .button_raw(button_raw),
      .level_o   (level_o),
      .press_o   (press_o),
      .release_o (release_o),
      .long_o    (long_o),
      .fsm_state (fsm_state)
   );

   // Clock generation and the rising-edge counter.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // Global time limit for the whole run.
   initial begin
      #200000;
      $display("FAIL watchdog: actual run still active at %0t, required finish before 200000", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic logic [23:0] mk_ev(input int edge_n, input logic [3:0] kind, input int ch);
      return {16'(edge_n), kind, 4'(ch)};
   endfunction

   task automatic expect_ev(input int edge_n, input logic [3:0] kind, input int ch);
      exp_q.push_back(mk_ev(edge_n, kind, ch));
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // Waits on falling edges until the falling edge that follows edge tgt.
   task automatic goto_edge(input int tgt);
      int guard;
      guard = 0;
      while (cyc < tgt && guard < 1000) begin
         @(negedge clock);
         guard++;
      end
      if (cyc != tgt) begin
         checks++;
         fails++;
         $display("FAIL goto_edge: actual edge %0d, required %0d", cyc, tgt);
      end
   endtask

   task automatic check_drained(input string name);
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   // Monitor: every pulse the DUT presents is matched against the queue.
   always @(negedge clock) begin
      if (reset_n) begin
         for (int ch = 0; ch < N; ch++) begin
            mon_ev = {long_o[ch], release_o[ch], press_o[ch]};
            if (mon_ev != 3'b000) begin
               checks++;
               if ($countones(mon_ev) > 1) begin
                  fails++;
                  $display("FAIL exclusive_ch%0d: actual pulses %b, required one-hot", ch, mon_ev);
               end
               for (int k = 0; k < 3; k++) begin
                  if (mon_ev[k]) begin
                     mon_act = mk_ev(cyc, 4'(k + 1), ch);
                     checks++;
                     if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_event: actual edge=%0d kind=%0d ch=%0d, required none",
                                 cyc, k + 1, ch);
                     end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_act !== mon_exp) begin
                           fails++;
                           $display("FAIL event: actual edge=%0d kind=%0d ch=%0d, required edge=%0d kind=%0d ch=%0d",
                                    mon_act[23:8], mon_act[7:4], mon_act[3:0],
                                    mon_exp[23:8], mon_exp[7:4], mon_exp[3:0]);
                        end
                     end
                  end
               end
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      int base;
      checks     = 0;
      fails      = 0;
      reset_n    = 1'b0;
      button_raw = '1;

      // Reset state.
      repeat (3) @(negedge clock);
      check("reset_outputs", {level_o, press_o, release_o, long_o}, 32'd0);
      check("reset_state", 32'(fsm_state), 32'd0);
      reset_n = 1'b1;
      goto_edge(cyc + 2);

      // Channel 0: press latency, level window and release latency.
      base = cyc;
      expect_ev(base + 7, K_PRESS, 0);
      expect_ev(base + 15, K_RELEASE, 0);
      button_raw[0] = 1'b0;
      goto_edge(base + 6);
      check("ch0_level_before_press", 32'(level_o), 32'h0);
      goto_edge(base + 7);
      check("ch0_level_at_press", 32'(level_o), 32'h1);
      goto_edge(base + 8);
      button_raw[0] = 1'b1;
      goto_edge(base + 14);
      check("ch0_level_before_release", 32'(level_o), 32'h1);
      goto_edge(base + 15);
      check("ch0_level_at_release", 32'(level_o), 32'h0);
      goto_edge(base + 17);
      check_drained("ch0_drained");

      // Channel 1: glitches of 3 and DEB raw cycles are rejected.
      base = cyc;
      button_raw[1] = 1'b0;
      goto_edge(base + 3);
      button_raw[1] = 1'b1;
      goto_edge(base + 10);
      base = cyc;
      button_raw[1] = 1'b0;
      goto_edge(base + 4);
      button_raw[1] = 1'b1;
      goto_edge(base + 12);
      check("ch1_glitch_level", 32'(level_o), 32'h0);
      check("ch1_glitch_state", 32'(fsm_state[3:2]), 32'd0);
      check_drained("ch1_drained");

      // Channel 3: the shortest accepted pulse, DEB+1 raw cycles.
      base = cyc;
      expect_ev(base + 7, K_PRESS, 3);
      expect_ev(base + 12, K_RELEASE, 3);
      button_raw[3] = 1'b0;
      goto_edge(base + 5);
      button_raw[3] = 1'b1;
      goto_edge(base + 7);
      check("ch3_level_min_press", 32'(level_o), 32'h8);
      goto_edge(base + 14);
      check_drained("ch3_drained");

      // Channel 2: hold for 20 cycles, producing press, long and release.
      base = cyc;
      expect_ev(base + 7, K_PRESS, 2);
      expect_ev(base + 17, K_LONG, 2);
      expect_ev(base + 27, K_RELEASE, 2);
      button_raw[2] = 1'b0;
      goto_edge(base + 20);
      button_raw[2] = 1'b1;
      goto_edge(base + 26);
      check("ch2_level_before_release", 32'(level_o), 32'h4);
      goto_edge(base + 27);
      check("ch2_level_at_release", 32'(level_o), 32'h0);
      goto_edge(base + 30);
      check_drained("ch2_drained");

      // Channel 2: a two-cycle release bounce while held.
      base = cyc;
      expect_ev(base + 7, K_PRESS, 2);
      expect_ev(base + 17, K_LONG, 2);
      expect_ev(base + 27, K_RELEASE, 2);
      button_raw[2] = 1'b0;
      goto_edge(base + 9);
      button_raw[2] = 1'b1;
      goto_edge(base + 11);
      button_raw[2] = 1'b0;
      goto_edge(base + 13);
      check("ch2_level_during_bounce", 32'(level_o), 32'h4);
      goto_edge(base + 20);
      button_raw[2] = 1'b1;
      goto_edge(base + 30);
      check_drained("ch2_bounce_drained");

      // All channels pressed together, then reset applied while held.
      base = cyc;
      for (int ch = 0; ch < N; ch++) expect_ev(base + 7, K_PRESS, ch);
      button_raw = '0;
      goto_edge(base + 9);
      check("all_level_held", 32'(level_o), 32'hF);
      check("all_state_held", 32'(fsm_state), 32'hAA);
      reset_n = 1'b0;
      #1;
      check("midrun_reset_outputs", {level_o, press_o, release_o, long_o}, 32'd0);
      check("midrun_reset_state", 32'(fsm_state), 32'd0);
      goto_edge(base + 11);
      reset_n = 1'b1;
      base = cyc;
      for (int ch = 0; ch < N; ch++) expect_ev(base + 7, K_PRESS, ch);
      for (int ch = 0; ch < N; ch++) expect_ev(base + 16, K_RELEASE, ch);
      goto_edge(base + 6);
      check("repress_level_before", 32'(level_o), 32'h0);
      goto_edge(base + 7);
      check("repress_level_at", 32'(level_o), 32'hF);
      goto_edge(base + 9);
      button_raw = '1;
      goto_edge(base + 20);
      check("final_level", 32'(level_o), 32'h0);
      check_drained("final_drained");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N, default 4: number of independent button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: stable-sample count for acceptance (20 ms at 50 MHz); legal range 2 or more.
REQ-003 Parameter LONG_CYCLES, default 50000000: hold time for a long-press event (1 s at 50 MHz); legal range greater than DEBOUNCE_CYCLES.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means raw input 0 is "pressed" (pull-up buttons); 0 means raw input 1 is "pressed".
REQ-005 clock  input  1  single system clock (CLOCK_50 domain).
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 button_raw  input  N  asynchronous raw button/DIP levels.
REQ-008 level_o  output  N  debounced state per channel; 1 = pressed.
REQ-009 press_o  output  N  one-cycle pulse on accepted press.
REQ-010 release_o  output  N  one-cycle pulse on accepted release.
REQ-011 long_o  output  N  one-cycle pulse when a press has been held LONG_CYCLES.

Function
REQ-012 Each channel SHALL pass its raw input through a two-flop synchronizer, then normalise polarity per ACTIVE_LOW, giving sync_pressed.
REQ-013 Each channel SHALL run an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a debounce counter and a hold counter; both counters are sized by $clog2 of their limit.
REQ-014 IDLE: when sync_pressed=1, go to PRESS_WAIT and set the debounce counter to 0; otherwise stay.
REQ-015 PRESS_WAIT: when sync_pressed=0, return to IDLE with no event; when the counter equals DEBOUNCE_CYCLES-1, go to HELD, set level_o=1, pulse press_o and clear the hold counter; otherwise increment the counter.
REQ-016 Press latency SHALL be exact: press_o is high in the cycle following the (DEBOUNCE_CYCLES+3)th rising edge, counting the edge that first samples the pressed raw level as edge 1.
REQ-017 HELD: the hold counter increments and saturates at LONG_CYCLES-1. On the edge where it reaches LONG_CYCLES-1, pulse long_o exactly once per press. When sync_pressed=0, go to RELEASE_WAIT and clear the debounce counter.
REQ-018 RELEASE_WAIT: when sync_pressed=1, return to HELD with no event, the hold counter not cleared and no new press_o. When the counter equals DEBOUNCE_CYCLES-1, go to IDLE, set level_o=0 and pulse release_o; otherwise increment.
REQ-019 A long-press event SHALL continue to accrue during RELEASE_WAIT bounces; long_o SHALL NOT fire after release_o for the same press.
REQ-020 press_o, release_o and long_o SHALL be registered, high for exactly one cycle, and mutually exclusive per channel in any cycle.
REQ-021 level_o SHALL stay 1 from the press_o cycle until the release_o cycle, inclusive of the press_o cycle and exclusive of the release_o cycle.
REQ-022 Channels SHALL NOT interact; simultaneous events on different channels SHALL all be reported in the same cycle.
REQ-023 A pulse shorter than DEBOUNCE_CYCLES+1 cycles, after synchronization, SHALL produce no output change.

Reset
REQ-024 While reset_n=0, all outputs SHALL be 0, every FSM SHALL be IDLE, counters SHALL be 0, and synchronizer flops SHALL hold the "released" raw value (1 when ACTIVE_LOW=1).
REQ-025 Reset asserted mid-operation (any state) SHALL take effect immediately and SHALL NOT generate release_o; after deassertion, a still-held button SHALL be re-debounced and reported as a new press_o.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, N=4, ACTIVE_LOW=1)
REQ-026 Hold button_raw[0]=0 from edge 1 -> press_o[0] high only after edge 7, level_o[0]=1 from edge 7; no other channel changes.
REQ-027 Glitch button_raw[1]=0 for 3 cycles, then 1 -> level_o, press_o, release_o and long_o on channel 1 all stay 0.
REQ-028 Hold channel 2 for 20 cycles -> press_o after edge 7, single long_o after edge 17, release_o exactly DEBOUNCE_CYCLES+3 edges after the raw release.
REQ-029 While HELD, bounce release for 2 cycles -> no release_o and no second press_o; long_o timing unchanged.
REQ-030 All four channels pressed on the same edge -> all press_o bits high in the same cycle; reset_n pulsed low during HELD -> outputs 0 at once, no release_o, and a re-press is reported 7 edges after deassertion.
